nrd_seq_controller: RTL and testbench

Sequential controller for the non-restoring divider datapath. It reuses one (2*Nx-1)-bit add/sub row over Nx iterations plus one correction step, instead of the unrolled Nx+1-row array. A valid/ready handshake wraps it on both sides. Results are bit-identical to the combinational array for every input, including divisor zero and quotient overflow. It sits between the operand producer and the result consumer in the divider test harness.

---
 rtl/nrd_pkg.sv | 19 +
 rtl/nrd_addsub_row.sv | 56 +++++
 rtl/nrd_seq_controller.sv | 187 ++++++++++++++++++
 tb/tb_nrd_seq_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nrd_pkg.sv
// Shared definitions for the sequential non-restoring divider controller.
// Holds the default quotient width, derived operand widths, counter width
// and the 2-bit FSM state encoding.
package nrd_pkg;

  localparam int unsigned NRD_NX = 5;
  localparam int unsigned NRD_DW = NRD_NX - 1;
  localparam int unsigned NRD_RW = 2 * NRD_NX - 2;
  localparam int unsigned NRD_PW = 2 * NRD_NX - 1;
  localparam int unsigned NRD_CW = $clog2(NRD_NX);

  typedef logic [1:0] nrd_state_t;

  localparam nrd_state_t ST_IDLE = 2'd0;
  localparam nrd_state_t ST_ITER = 2'd1;
  localparam nrd_state_t ST_CORR = 2'd2;
  localparam nrd_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/nrd_addsub_row.sv
// One ripple add/sub row of full_adder cells, shared by every divider step.
// Ports:
//   a      : partial remainder
//   b      : shifted divisor operand
//   en     : 0 forces the operand to zero (correction step with no add-back)
//   inv    : 1 inverts the operand (subtract when combined with cin=1)
//   cin    : carry-in
//   sum_c  : a + ((b & en) ^ inv) + cin, modulo 2^W
//   cout_c : carry-out of the top bit

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s_c,
  output logic co_c
);

  assign s_c  = a ^ b ^ ci;
  assign co_c = (a & b) | (ci & (a ^ b));

endmodule

module nrd_addsub_row
  import nrd_pkg::*;
#(
  parameter int unsigned W = NRD_PW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         en,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic [W-1:0] bx;
  logic [W:0]   cy;

  assign bx    = (b & {W{en}}) ^ {W{inv}};
  assign cy[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (bx[i]),
      .ci  (cy[i]),
      .s_c (sum_c[i]),
      .co_c(cy[i+1])
    );
  end

  assign cout_c = cy[W];

endmodule

// File: rtl/nrd_seq_controller.sv
// Sequential non-restoring divider: one shared add/sub row is used over Nx
// iterations plus one correction step, wrapped in valid/ready handshakes.
// Results match the unrolled array bit for bit, including divisor zero and
// quotient overflow.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_valid / o_ready      : operand handshake (o_ready high only in IDLE)
//   i_d_nosign, i_r_nosign : unsigned divisor (Nx-1 bits), dividend (2*Nx-2)
//   o_valid / i_ready      : result handshake
//   o_quotient, o_remainder: result, held until the next correction step
// Optional (macro NRD_SEQ_STATUS_EN):
//   o_div_zero, o_overflow : status flags, registered alongside the result
module nrd_seq_controller
  import nrd_pkg::*;
#(
  parameter int unsigned Nx = NRD_NX
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [Nx-2:0]   i_d_nosign,
  input  logic [2*Nx-3:0] i_r_nosign,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [Nx-1:0]   o_quotient,
  output logic [2*Nx-2:0] o_remainder
`ifdef NRD_SEQ_STATUS_EN
  ,
  output logic            o_div_zero,
  output logic            o_overflow
`endif
);

  localparam int unsigned DW = Nx - 1;
  localparam int unsigned PW = 2 * Nx - 1;
  localparam int unsigned CW = $clog2(Nx);

  nrd_state_t    state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] d_q, d_d;
  logic [CW-1:0] n_q, n_d;
  logic          c_q, c_d;
  logic [Nx-1:0] q_q, q_d;
  logic [Nx-1:0] quo_d;
  logic [PW-1:0] rem_d;
  logic          ready_d, valid_d;

  logic [CW-1:0] shamt_c;
  logic [PW-1:0] row_b_c, row_sum_c;
  logic          row_en_c, row_inv_c, row_cin_c, row_co_c;

`ifdef NRD_SEQ_STATUS_EN
  logic dz_pend_q, dz_pend_d, ov_pend_q, ov_pend_d;
  logic dz_d, ov_d;
`endif

  // Row operand: shifted divisor during iterations, plain divisor (or zero) in correction
  always_comb begin
    shamt_c   = CW'(Nx - 1) - n_q;
    row_b_c   = PW'(d_q);
    row_en_c  = 1'b1;
    row_inv_c = 1'b0;
    row_cin_c = 1'b0;
    if (state_q == ST_ITER) begin
      row_b_c   = PW'(d_q) << shamt_c;
      row_inv_c = c_q;
      row_cin_c = c_q;
    end else begin
      row_en_c  = ~c_q;
    end
  end

  nrd_addsub_row #(.W(PW)) u_row (
    .a     (p_q),
    .b     (row_b_c),
    .en    (row_en_c),
    .inv   (row_inv_c),
    .cin   (row_cin_c),
    .sum_c (row_sum_c),
    .cout_c(row_co_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    d_d     = d_q;
    n_d     = n_q;
    c_d     = c_q;
    q_d     = q_q;
    quo_d   = o_quotient;
    rem_d   = o_remainder;
    ready_d = o_ready;
    valid_d = o_valid;
`ifdef NRD_SEQ_STATUS_EN
    dz_pend_d = dz_pend_q;
    ov_pend_d = ov_pend_q;
    dz_d      = o_div_zero;
    ov_d      = o_overflow;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          d_d     = i_d_nosign;
          p_d     = {1'b0, i_r_nosign};
          c_d     = 1'b1;
          n_d     = '0;
          q_d     = '0;
          ready_d = 1'b0;
          state_d = ST_ITER;
`ifdef NRD_SEQ_STATUS_EN
          dz_pend_d = (i_d_nosign == '0);
          ov_pend_d = (i_d_nosign != '0) &&
                      ({1'b0, i_r_nosign} >= (PW'(i_d_nosign) << Nx));
`endif
        end
      end
      ST_ITER: begin
        p_d = row_sum_c;
        c_d = row_co_c;
        q_d = q_q | (Nx'(row_co_c) << shamt_c);
        n_d = n_q + CW'(1);
        if (n_q == CW'(Nx - 1)) state_d = ST_CORR;
      end
      ST_CORR: begin
        p_d     = row_sum_c;
        quo_d   = q_q;
        rem_d   = row_sum_c;
        valid_d = 1'b1;
        state_d = ST_DONE;
`ifdef NRD_SEQ_STATUS_EN
        dz_d = dz_pend_q;
        ov_d = ov_pend_q;
`endif
      end
      ST_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      d_q         <= '0;
      n_q         <= '0;
      c_q         <= 1'b0;
      q_q         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
`ifdef NRD_SEQ_STATUS_EN
      dz_pend_q   <= 1'b0;
      ov_pend_q   <= 1'b0;
      o_div_zero  <= 1'b0;
      o_overflow  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      d_q         <= d_d;
      n_q         <= n_d;
      c_q         <= c_d;
      q_q         <= q_d;
      o_quotient  <= quo_d;
      o_remainder <= rem_d;
      o_ready     <= ready_d;
      o_valid     <= valid_d;
`ifdef NRD_SEQ_STATUS_EN
      dz_pend_q   <= dz_pend_d;
      ov_pend_q   <= ov_pend_d;
      o_div_zero  <= dz_d;
      o_overflow  <= ov_d;
`endif
    end
  end

endmodule

// File: tb/tb_nrd_seq_controller.sv
// Self-checking bench for nrd_seq_controller: vector table, random in-range
// divisions, backpressure and asynchronous reset sequences.
module tb_nrd_seq_controller;
  import nrd_pkg::*;

  localparam int unsigned NX = NRD_NX;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [NRD_DW-1:0] i_d;
  logic [NRD_RW-1:0] i_r;
  logic              o_valid;
  logic              i_ready;
  logic [NX-1:0]     o_q;
  logic [NRD_PW-1:0] o_rem;
`ifdef NRD_SEQ_STATUS_EN
  logic              o_dz;
  logic              o_ov;
`endif

  nrd_seq_controller #(.Nx(NX)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_d_nosign (i_d),
    .i_r_nosign (i_r),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_quotient (o_q),
    .o_remainder(o_rem)
`ifdef NRD_SEQ_STATUS_EN
    ,
    .o_div_zero (o_dz),
    .o_overflow (o_ov)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NRD_DW-1:0] d;
    logic [NRD_RW-1:0] r;
    logic [NX-1:0]     q;
    logic [NRD_PW-1:0] rem;
    logic              dz;
    logic              ov;
  } vec_t;

  typedef struct {
    logic [NX-1:0]     q;
    logic [NRD_PW-1:0] rem;
    logic              dz;
    logic              ov;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for o_ready, present operands, leave one cycle after the accept edge
  task automatic start(input logic [NRD_DW-1:0] d, input logic [NRD_RW-1:0] r, input exp_t e);
    int k = 0;
    while (!o_ready && k < 50) begin step(); k++; end
    check("accept_ready", 32'(o_ready), 32'd1);
    i_d     = d;
    i_r     = r;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_d     = ~d;
    i_r     = ~r;
    sb.push_back(e);
  endtask

  // Wait for o_valid (bounded), compare against the scoreboard head
  task automatic finish_div(input string name);
    int   lat = 0;
    exp_t e;
    while (!o_valid && lat < 20) begin step(); lat++; end
    check({name, "_latency"}, 32'(lat), 32'(NX + 1));
    if (!o_valid) return;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, "_q"}, 32'(o_q), 32'(e.q));
    check({name, "_rem"}, 32'(o_rem), 32'(e.rem));
`ifdef NRD_SEQ_STATUS_EN
    check({name, "_dz"}, 32'(o_dz), 32'(e.dz));
    check({name, "_ov"}, 32'(o_ov), 32'(e.ov));
`endif
    check({name, "_busy_ready"}, 32'(o_ready), 32'd0);
    if (i_ready) begin
      step();
      check({name, "_release"}, {30'd0, o_valid, o_ready}, 32'b01);
    end
  endtask

  vec_t vecs[8];
  exp_t e;

  initial begin
    vecs[0] = '{d: 4'd7,  r: 8'd100,  q: 5'd14, rem: 9'd2,    dz: 1'b0, ov: 1'b0};
    vecs[1] = '{d: 4'd15, r: 8'd255,  q: 5'd17, rem: 9'd0,    dz: 1'b0, ov: 1'b0};
    vecs[2] = '{d: 4'd1,  r: 8'd0,    q: 5'd0,  rem: 9'd0,    dz: 1'b0, ov: 1'b0};
    vecs[3] = '{d: 4'd0,  r: 8'h5A,   q: 5'h1F, rem: 9'h05A,  dz: 1'b1, ov: 1'b0};
    vecs[4] = '{d: 4'd1,  r: 8'd255,  q: 5'h1F, rem: 9'd224,  dz: 1'b0, ov: 1'b1};
    vecs[5] = '{d: 4'd1,  r: 8'd31,   q: 5'd31, rem: 9'd0,    dz: 1'b0, ov: 1'b0};
    vecs[6] = '{d: 4'd1,  r: 8'd32,   q: 5'h1F, rem: 9'd1,    dz: 1'b0, ov: 1'b1};
    vecs[7] = '{d: 4'd3,  r: 8'd10,   q: 5'd3,  rem: 9'd1,    dz: 1'b0, ov: 1'b0};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_d     = '0;
    i_r     = '0;
    #23;
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_q", 32'(o_q), 32'd0);
    check("reset_rem", 32'(o_rem), 32'd0);
`ifdef NRD_SEQ_STATUS_EN
    check("reset_dz", 32'(o_dz), 32'd0);
    check("reset_ov", 32'(o_ov), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      e = '{q: vecs[i].q, rem: vecs[i].rem, dz: vecs[i].dz, ov: vecs[i].ov};
      start(vecs[i].d, vecs[i].r, e);
      finish_div($sformatf("vec%0d", i));
    end

    // Random in-range divisions checked against integer divide
    for (int i = 0; i < 8; i++) begin
      int unsigned d, r, lim;
      d   = $urandom_range(1, 15);
      lim = d * 32 - 1;
      if (lim > 255) lim = 255;
      r   = $urandom_range(0, lim);
      e   = '{q: NX'(r / d), rem: NRD_PW'(r % d), dz: 1'b0, ov: 1'b0};
      start(NRD_DW'(d), NRD_RW'(r), e);
      finish_div($sformatf("rnd%0d", i));
    end

    // Backpressure: result held while new operands wait
    i_ready = 1'b0;
    start(4'd5, 8'd77, '{q: 5'd15, rem: 9'd2, dz: 1'b0, ov: 1'b0});
    finish_div("bp");
    i_valid = 1'b1;
    i_d     = 4'd2;
    i_r     = 8'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold%0d_valid", i), 32'(o_valid), 32'd1);
      check($sformatf("bp_hold%0d_ready", i), 32'(o_ready), 32'd0);
      check($sformatf("bp_hold%0d_q", i), 32'(o_q), 32'd15);
      check($sformatf("bp_hold%0d_rem", i), 32'(o_rem), 32'd2);
    end
    i_ready = 1'b1;
    step();
    check("bp_release", {30'd0, o_valid, o_ready}, 32'b01);
    sb.push_back('{q: 5'd4, rem: 9'd1, dz: 1'b0, ov: 1'b0});
    step();
    i_valid = 1'b0;
    check("bp_next_taken", 32'(o_ready), 32'd0);
    finish_div("bp_next");

    // Asynchronous reset two iterations into a division
    start(4'd7, 8'd100, '{q: 5'd14, rem: 9'd2, dz: 1'b0, ov: 1'b0});
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    sb.delete();
    #3 rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (o_valid) seen = 1'b1;
      end
      check("arst_no_stale_valid", 32'(seen), 32'd0);
    end
    start(4'd3, 8'd10, '{q: 5'd3, rem: 9'd1, dz: 1'b0, ov: 1'b0});
    finish_div("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
